// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - launch/completion controller holding the core in reset between bounded runs
module run_sequencer #(
    parameter int RST_CYC = 2,
    parameter int CW      = 12,
    parameter int MAX_CYC = 4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    output logic          core_reset,
    output logic          busy,
    output logic          ack,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);
    localparam int              HW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HW-1:0]   HOLD_INIT = HW'(RST_CYC - 1);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(MAX_CYC);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        FINISH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          r_core_reset;
    logic          r_busy;
    logic          r_ack;

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt   = HOLD;
                    w_hold_nxt    = HOLD_INIT;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (r_hold == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            RUN: begin
                // done takes priority over the limit, so a run finishing on the last cycle is not a timeout
                if (core_done) begin
                    w_state_nxt = FINISH;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = FINISH;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_cnt        <= w_cnt_nxt;
            r_timeout    <= w_timeout_nxt;
            r_core_reset <= (w_state_nxt != RUN);
            r_busy       <= (w_state_nxt == HOLD) || (w_state_nxt == RUN);
            r_ack        <= (w_state_nxt == FINISH);
        end
    end

    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign ack        = r_ack;
    assign timeout    = r_timeout;
    assign cycle_cnt  = r_cnt;

endmodule
